// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits, optional even parity, stop bit.
// One bit per clock; presents each accepted word with a one-cycle valid strobe.
module serial_frame_rx #(
  parameter int WIDTH     = 8,
  parameter int PARITY_EN = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    RESYNC
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             par_q, par_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             parity_err_q, parity_err_d;
  logic             frame_err_q, frame_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shreg_q      <= '0;
      par_q        <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      par_q        <= par_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shreg_d      = shreg_q;
    par_d        = par_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (serial_in) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        // The first received bit ends up at the MSB or LSB depending on shift direction.
        if (MSB_FIRST != 0) begin
          shreg_d = {shreg_q[WIDTH-2:0], serial_in};
        end else begin
          shreg_d = {serial_in, shreg_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        par_d   = serial_in;
        state_d = STOP;
      end
      STOP: begin
        if (serial_in) begin
          state_d     = RESYNC;
          frame_err_d = 1'b1;
        end else begin
          state_d      = IDLE;
          data_out_d   = shreg_q;
          data_valid_d = 1'b1;
          parity_err_d = (PARITY_EN != 0) && ((^shreg_q) != par_q);
        end
      end
      RESYNC: begin
        // A line stuck high must fall back to 0 before a new start can be seen.
        if (!serial_in) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed and randomized frames against an MSB-first and an LSB-first receiver
// sharing one serial line; expectations come from a word-level model.
module tb_serial_frame_rx;

  logic       clk;
  logic       rst;
  logic       serial_in;
  logic [7:0] dout_m, dout_l;
  logic       dv_m, pe_m, fe_m, busy_m;
  logic       dv_l, pe_l, fe_l, busy_l;

  int vectors;
  int miscompares;
  int cyc;
  logic [7:0] prev_m, prev_l;
  int last_valid_cyc;

  serial_frame_rx #(.WIDTH(8), .PARITY_EN(1), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .serial_in(serial_in),
    .data_out(dout_m), .data_valid(dv_m), .parity_err(pe_m),
    .frame_err(fe_m), .busy(busy_m)
  );

  serial_frame_rx #(.WIDTH(8), .PARITY_EN(1), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .serial_in(serial_in),
    .data_out(dout_l), .data_valid(dv_l), .parity_err(pe_l),
    .frame_err(fe_l), .busy(busy_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7 - i];
    return r;
  endfunction

  task automatic chk_all(input string tag, input logic [7:0] exp_m, input logic [7:0] exp_l,
                         input logic dv, input logic pe, input logic fe, input logic bsy);
    chk({tag, "_dout_m"}, 32'(dout_m), 32'(exp_m));
    chk({tag, "_dout_l"}, 32'(dout_l), 32'(exp_l));
    chk({tag, "_dv_m"}, 32'(dv_m), 32'(dv));
    chk({tag, "_dv_l"}, 32'(dv_l), 32'(dv));
    chk({tag, "_pe_m"}, 32'(pe_m), 32'(pe));
    chk({tag, "_pe_l"}, 32'(pe_l), 32'(pe));
    chk({tag, "_fe_m"}, 32'(fe_m), 32'(fe));
    chk({tag, "_fe_l"}, 32'(fe_l), 32'(fe));
    chk({tag, "_busy_m"}, 32'(busy_m), 32'(bsy));
    chk({tag, "_busy_l"}, 32'(busy_l), 32'(bsy));
  endtask

  // Entered and left at a falling edge; the first bit is driven immediately.
  task automatic send_frame(input string tag, input logic [7:0] w, input logic flip, input logic stopb);
    logic [10:0] bits;
    logic        ok;
    bits = {1'b1, w, (^w) ^ flip, stopb};
    for (int i = 10; i >= 0; i--) begin
      if (i < 10) begin
        @(negedge clk);
        chk({tag, "_busy_in_frame"}, 32'(busy_m & busy_l), 32'd1);
        chk({tag, "_pulse_in_frame"}, 32'({dv_m, dv_l, fe_m, fe_l}), 32'd0);
      end
      serial_in = bits[i];
    end
    @(negedge clk);
    ok = !stopb;
    if (ok) begin
      prev_m = w;
      prev_l = rev8(w);
      last_valid_cyc = cyc;
    end
    chk_all(tag, prev_m, prev_l, ok, ok & flip, stopb, stopb);
  endtask

  task automatic idle(input int n);
    serial_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic resync(input string tag, input int hold);
    serial_in = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk_all({tag, "_resync_hold"}, prev_m, prev_l, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    serial_in = 1'b0;
    @(negedge clk);
    chk_all({tag, "_resync_done"}, prev_m, prev_l, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int first_cyc;
    logic [7:0] w;
    logic flip, stopb;
    vectors = 0;
    miscompares = 0;
    prev_m = 8'h00;
    prev_l = 8'h00;
    last_valid_cyc = 0;
    rst = 1'b1;
    serial_in = 1'b0;

    // Reset with the line toggling
    @(negedge clk);
    serial_in = 1'b1;
    @(negedge clk);
    serial_in = 1'b0;
    @(negedge clk);
    chk_all("reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    idle(2);
    chk_all("post_reset_idle", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Good frame, then parity error on the same word
    send_frame("good_a5", 8'hA5, 1'b0, 1'b0);
    idle(1);
    chk_all("after_pulse", 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame("parity_err_a5", 8'hA5, 1'b1, 1'b0);
    idle(2);

    // Frame error, line held high 5 cycles, then released
    send_frame("frame_err", 8'h5A, 1'b0, 1'b1);
    resync("frame_err", 5);
    idle(1);

    // Back-to-back frames
    send_frame("b2b_3c", 8'h3C, 1'b0, 1'b0);
    first_cyc = last_valid_cyc;
    send_frame("b2b_ff", 8'hFF, 1'b0, 1'b0);
    chk("b2b_spacing", 32'(last_valid_cyc - first_cyc), 32'd11);
    idle(2);

    // Reset after 4 data bits
    serial_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      serial_in = i[0];
    end
    @(negedge clk);
    rst = 1'b1;
    serial_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    prev_m = 8'h00;
    prev_l = 8'h00;
    chk_all("mid_frame_reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    chk_all("mid_frame_reset_quiet", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame("after_reset_01", 8'h01, 1'b0, 1'b0);
    idle(1);

    // Randomized frames
    for (int n = 0; n < 40; n++) begin
      w     = 8'($urandom_range(0, 255));
      flip  = ($urandom_range(0, 3) == 0);
      stopb = ($urandom_range(0, 5) == 0);
      send_frame("rand", w, flip, stopb);
      if (stopb) resync("rand", int'($urandom_range(0, 3)));
      idle(int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
